// File: rtl/coin_acceptor.sv
// coin_acceptor: synchronizes and debounces two coin sensors, classifies coin events, tracks jams and a saturating total.
module coin_acceptor #(
  parameter int DEB_CYCLES = 4,
  parameter int JAM_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sense5,
  input  logic       sense10,
  input  logic       enable,
  output logic [1:0] coin,
  output logic       reject,
  output logic       jam,
  output logic [7:0] total
);
  localparam logic [7:0]  DEB = 8'(DEB_CYCLES);
  localparam logic [15:0] JAMC = 16'(JAM_CYCLES);
  typedef enum logic {IDLE, JAM} state_t;
  state_t state, next;
  logic [1:0] s1, s2, deb, dq, rise, hit;
  logic [7:0] cnt [2];
  logic [15:0] hc [2];
  logic [1:0] coin_n;
  logic reject_n;
  logic [7:0] total_n;
  logic [8:0] sum;
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
      deb <= '0;
      dq <= '0;
      for (int i = 0; i < 2; i++) begin
        cnt[i] <= '0;
        hc[i] <= '0;
      end
      state <= IDLE;
      coin <= '0;
      reject <= 1'b0;
      jam <= 1'b0;
      total <= '0;
    end else begin
      s1 <= {sense10, sense5};
      s2 <= s1;
      dq <= deb;
      for (int i = 0; i < 2; i++) begin
        if (cnt[i] == DEB) begin
          deb[i] <= ~deb[i];
          cnt[i] <= '0;
        end else
          cnt[i] <= (s2[i] != deb[i]) ? cnt[i] + 8'd1 : '0;
        hc[i] <= !deb[i] ? '0 : (hc[i] == JAMC) ? hc[i] : hc[i] + 16'd1;
      end
      state <= next;
      coin <= coin_n;
      reject <= reject_n;
      jam <= (next == JAM);
      total <= total_n;
    end
  end
  // bit 0 is the 5-rupee path, bit 1 the 10-rupee path; coin code equals the rise vector
  always_comb begin
    rise = deb & ~dq;
    hit = {hc[1] == JAMC, hc[0] == JAMC};
    sum = {1'b0, total} + (rise[1] ? 9'd10 : 9'd5);
    next = state;
    coin_n = '0;
    reject_n = 1'b0;
    total_n = total;
    if (state == IDLE) begin
      if (|hit)
        next = JAM;
      else if (|rise) begin
        if (!enable || &rise)
          reject_n = 1'b1;
        else begin
          coin_n = rise;
          total_n = sum[8] ? 8'hff : sum[7:0];
        end
      end
    end else if (deb == 2'b00)
      next = IDLE;
  end
endmodule

// File: tb/tb_coin_acceptor.sv
// tb_coin_acceptor: randomized and directed checks of coin_acceptor against a behavioural model.
module tb_coin_acceptor;
  localparam int DEB = 4;
  localparam int JAMC = 16;
  logic clk = 1'b0;
  logic rst, sense5, sense10, enable;
  logic [1:0] coin;
  logic reject, jam;
  logic [7:0] total;
  int n_chk = 0, n_err = 0;
  int ncoin, nrej, njam;
  int m_s1 [2], m_s2 [2], m_deb [2], m_dq [2], m_cnt [2], m_hc [2];
  int m_jamst, m_coin, m_rej, m_total;

  coin_acceptor #(.DEB_CYCLES(DEB), .JAM_CYCLES(JAMC)) dut (
    .clk(clk), .rst(rst), .sense5(sense5), .sense10(sense10), .enable(enable),
    .coin(coin), .reject(reject), .jam(jam), .total(total)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model(input logic r, input logic a, input logic b, input logic en);
    int in [2];
    int r0, r1, hit, both_low, nd;
    if (r) begin
      for (int i = 0; i < 2; i++) begin
        m_s1[i] = 0; m_s2[i] = 0; m_deb[i] = 0; m_dq[i] = 0; m_cnt[i] = 0; m_hc[i] = 0;
      end
      m_jamst = 0; m_coin = 0; m_rej = 0; m_total = 0;
      return;
    end
    in[0] = int'(a);
    in[1] = int'(b);
    r0 = (m_deb[0] == 1 && m_dq[0] == 0) ? 1 : 0;
    r1 = (m_deb[1] == 1 && m_dq[1] == 0) ? 1 : 0;
    hit = (m_hc[0] == JAMC || m_hc[1] == JAMC) ? 1 : 0;
    both_low = (m_deb[0] == 0 && m_deb[1] == 0) ? 1 : 0;
    for (int i = 0; i < 2; i++) begin
      nd = m_deb[i];
      if (m_cnt[i] == DEB) begin
        nd = 1 - m_deb[i];
        m_cnt[i] = 0;
      end else
        m_cnt[i] = (m_s2[i] != m_deb[i]) ? m_cnt[i] + 1 : 0;
      m_hc[i] = (m_deb[i] == 0) ? 0 : ((m_hc[i] + 1 > JAMC) ? JAMC : m_hc[i] + 1);
      m_dq[i] = m_deb[i];
      m_deb[i] = nd;
      m_s2[i] = m_s1[i];
      m_s1[i] = in[i];
    end
    m_coin = 0;
    m_rej = 0;
    if (m_jamst == 0) begin
      if (hit == 1)
        m_jamst = 1;
      else if (r0 + r1 > 0) begin
        if (!en || r0 + r1 == 2)
          m_rej = 1;
        else begin
          m_coin = r0 ? 1 : 2;
          m_total = (m_total + (r0 ? 5 : 10) > 255) ? 255 : m_total + (r0 ? 5 : 10);
        end
      end
    end else if (both_low == 1)
      m_jamst = 0;
  endtask

  task automatic step(input logic r, input logic a, input logic b, input logic en);
    rst = r; sense5 = a; sense10 = b; enable = en;
    @(posedge clk);
    model(r, a, b, en);
    #1;
    check("coin", 32'(coin), 32'(m_coin));
    check("reject", 32'(reject), 32'(m_rej));
    check("jam", 32'(jam), 32'(m_jamst));
    check("total", 32'(total), 32'(m_total));
    ncoin += (coin != 2'b00) ? 1 : 0;
    nrej += reject ? 1 : 0;
    njam += jam ? 1 : 0;
  endtask

  task automatic hold(input int n, input logic a, input logic b, input logic en);
    for (int i = 0; i < n; i++) step(1'b0, a, b, en);
  endtask

  task automatic restart();
    step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    ncoin = 0; nrej = 0; njam = 0;
  endtask

  initial begin
    logic a, b, en, r;
    a = 1'b0; b = 1'b0; en = 1'b1;
    restart();
    check("rst_coin", 32'(coin), 0);
    check("rst_total", 32'(total), 0);
    check("rst_jam", 32'(jam), 0);
    for (int j = 0; j < 10; j++) begin
      step(1'b0, 1'b1, 1'b0, 1'b1);
      check("lat5", 32'(coin), (j == 7) ? 1 : 0);
    end
    hold(10, 1'b0, 1'b0, 1'b1);
    check("t5_total", 32'(total), 5);
    check("t5_ncoin", 32'(ncoin), 1);
    ncoin = 0;
    hold(3, 1'b0, 1'b1, 1'b1);
    hold(12, 1'b0, 1'b0, 1'b1);
    check("glitch_coin", 32'(ncoin + nrej), 0);
    check("glitch_total", 32'(total), 5);
    restart();
    hold(10, 1'b1, 1'b1, 1'b1);
    hold(10, 1'b0, 1'b0, 1'b1);
    check("both_rej", 32'(nrej), 1);
    check("both_coin", 32'(ncoin), 0);
    check("both_total", 32'(total), 0);
    restart();
    hold(10, 1'b0, 1'b1, 1'b0);
    hold(10, 1'b0, 1'b0, 1'b0);
    check("dis_rej", 32'(nrej), 1);
    check("dis_coin", 32'(ncoin), 0);
    hold(10, 1'b0, 1'b1, 1'b1);
    hold(10, 1'b0, 1'b0, 1'b1);
    check("en_total", 32'(total), 10);
    check("en_ncoin", 32'(ncoin), 1);
    restart();
    hold(25, 1'b1, 1'b0, 1'b1);
    check("jam_on", 32'(jam), 1);
    hold(10, 1'b1, 1'b1, 1'b1);
    hold(5, 1'b1, 1'b0, 1'b1);
    hold(20, 1'b0, 1'b0, 1'b1);
    check("jam_ncoin", 32'(ncoin), 1);
    check("jam_total", 32'(total), 5);
    check("jam_off", 32'(jam), 0);
    restart();
    for (int k = 0; k < 26; k++) begin
      hold(8, 1'b0, 1'b1, 1'b1);
      hold(8, 1'b0, 1'b0, 1'b1);
    end
    check("sat_total", 32'(total), 255);
    check("sat_ncoin", 32'(ncoin), 26);
    hold(8, 1'b0, 1'b1, 1'b1);
    hold(8, 1'b0, 1'b0, 1'b1);
    check("sat_hold", 32'(total), 255);
    ncoin = 0;
    hold(4, 1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    check("mid_rst_total", 32'(total), 0);
    hold(12, 1'b0, 1'b0, 1'b1);
    check("mid_rst_coin", 32'(ncoin), 0);
    check("mid_rst_total2", 32'(total), 0);
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(7) == 0) a = ~a;
      if ($urandom_range(7) == 0) b = ~b;
      if ($urandom_range(19) == 0) en = ~en;
      r = ($urandom_range(299) == 0);
      step(r, a, b, en);
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/coin_acceptor.md
COIN_ACCEPTOR -- requirements
Module: coin_acceptor

Interface
REQ-001 Parameter DEB_CYCLES, default 4: consecutive synchronized cycles a sensor level must hold before the debounced level changes (legal 1..255).
REQ-002 Parameter JAM_CYCLES, default 1000: consecutive cycles a debounced sensor may stay high before a jam is declared (legal 2..65535).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-005 sense5  input  1  raw ₹5 coin-path sensor, asynchronous, high = coin present.
REQ-006 sense10  input  1  raw ₹10 coin-path sensor, asynchronous, high = coin present.
REQ-007 enable  input  1  1 = accept coins; 0 = reject all coins.
REQ-008 coin  output  2  registered coin code to the vending FSM: 00 none, 01 ₹5, 10 ₹10; 11 never driven.
REQ-009 reject  output  1  registered one-cycle pulse: coin detected but not accepted.
REQ-010 jam  output  1  registered level: sensor stuck high.
REQ-011 total  output  8  registered running sum of accepted value in rupees, saturating.

Function
REQ-012 Each sense line SHALL pass through a two-flop synchronizer before any other use.
REQ-013 Each line SHALL have an independent debouncer: counter increments while synchronized level differs from debounced level, clears when equal; debounced level flips and counter clears when counter reaches DEB_CYCLES.
REQ-014 A coin event SHALL be a debounced 0->1 transition; 1->0 transitions produce no event.
REQ-015 Latency: sense line sampled high at edge k and held SHALL give the coin pulse in the cycle after edge k+DEB_CYCLES+3.
REQ-016 coin SHALL be nonzero for exactly one cycle per accepted event and 00 otherwise.
REQ-017 FSM states: IDLE, JAM.
REQ-018 IDLE, enable=1, exactly one debounced rise: coin=01 (₹5) or 10 (₹10) next cycle; total += 5 or 10.
REQ-019 IDLE, both debounced rises in same cycle: no coin, reject=1 next cycle, total unchanged.
REQ-020 IDLE, enable=0, any debounced rise: no coin, reject=1 next cycle.
REQ-021 A rise on one line while the other debounced line is already high SHALL be accepted normally (independent paths).
REQ-022 Per-line high-time counter: counts cycles debounced level is high, clears when low; saturates at JAM_CYCLES.
REQ-023 IDLE -> JAM when either high-time counter reaches JAM_CYCLES; jam=1 from next cycle.
REQ-024 In JAM: coin=00 and reject=0 regardless of inputs; debounced rises discarded.
REQ-025 JAM -> IDLE only when both debounced levels are 0; jam=0 from next cycle; a rise in that same cycle SHALL be discarded.
REQ-026 total SHALL saturate at 255: sum >255 yields 255; no wrap.
REQ-027 enable SHALL affect only acceptance; debouncing, jam detection and counters run regardless.

Reset
REQ-028 On rst=1 at an edge: coin=00, reject=0, jam=0, total=0, FSM=IDLE, synchronizer and debounced levels=0, all counters=0.
REQ-029 Reset mid-debounce or mid-event SHALL discard the partial coin; a sensor high at reset release SHALL be debounced afresh and counted as a new rise.
REQ-030 rst SHALL take priority over every other input in the same cycle.

Verification (DEB_CYCLES=4, JAM_CYCLES=16)
REQ-031 sense5 high at edge k, held 10 cycles, enable=1 -> coin=01 exactly in cycle after edge k+7, total=5, reject=0.
REQ-032 sense10 glitch high 3 cycles then low -> coin stays 00, reject=0, total unchanged.
REQ-033 sense5 and sense10 rise together, held 10 cycles -> coin stays 00, one reject pulse, total=0.
REQ-034 enable=0, sense10 pulse of 10 cycles -> coin=00, one reject pulse; then enable=1, sense10 pulse -> coin=10, total=10.
REQ-035 sense5 held 40 cycles -> coin=01 once, jam=1 after 16 debounced-high cycles; sense10 pulse during jam -> no coin; release both -> jam=0 once both debounced low.
REQ-036 26 accepted ₹10 coins -> total=255 after 26th, stays 255; rst pulse mid-debounce of a further coin -> all outputs 0, no coin emitted.
